// File: rtl/tnn_pkg.sv
// Shared types and helpers for the sequential ternary neuron.
package tnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Ternary weight as {wneg, wpos}; both set cancels to zero
  localparam logic [1:0] WGT_ZERO   = 2'b00;
  localparam logic [1:0] WGT_POS    = 2'b01;
  localparam logic [1:0] WGT_NEG    = 2'b10;
  localparam logic [1:0] WGT_CANCEL = 2'b11;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Wide enough for N_IN * (2^W - 1) without overflow
  function automatic int unsigned acc_width(input int unsigned n_in, input int unsigned w);
    return w + clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/tnn_lane_adder.sv
// Combinational masked sum of one LANES-wide group of weighted activations.
module tnn_lane_adder
  import tnn_pkg::*;
#(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned W     = 3,
  parameter int unsigned LANES = 1,
  parameter int unsigned ACC_W = 6,
  parameter int unsigned GW    = 1
) (
  input  logic [N_IN*W-1:0] act_i,
  input  logic [N_IN-1:0]   wpos_i,
  input  logic [N_IN-1:0]   wneg_i,
  input  logic [GW-1:0]     grp_i,
  output logic [ACC_W-1:0]  pos_c,
  output logic [ACC_W-1:0]  neg_c
);

  int unsigned         base;
  logic [N_IN*W-1:0]   act_sh;
  logic [N_IN-1:0]     wpos_sh;
  logic [N_IN-1:0]     wneg_sh;
  logic [W-1:0]        lane_act;

  // Shift the current group down to lane 0; lanes past N_IN are masked off
  always_comb begin
    pos_c    = '0;
    neg_c    = '0;
    lane_act = '0;
    base     = 32'(grp_i) * LANES;
    act_sh   = act_i >> (base * W);
    wpos_sh  = wpos_i >> base;
    wneg_sh  = wneg_i >> base;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_act = act_sh[l*W +: W];
      if (base + l < N_IN) begin
        case ({wneg_sh[l], wpos_sh[l]})
          WGT_POS: pos_c = pos_c + ACC_W'(lane_act);
          WGT_NEG: neg_c = neg_c + ACC_W'(lane_act);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/tnn_seq_neuron.sv
// Multi-cycle ternary neuron: accumulates weighted activations LANES at a time.
// Optional signed threshold input enabled by TNN_THRESHOLD_EN.
module tnn_seq_neuron
  import tnn_pkg::*;
#(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned W     = 3,
  parameter int unsigned LANES = 1,
  localparam int unsigned ACC_W = acc_width(N_IN, W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_IN*W-1:0]   in_act,
  input  logic [N_IN-1:0]     in_wpos,
  input  logic [N_IN-1:0]     in_wneg,
`ifdef TNN_THRESHOLD_EN
  input  logic [ACC_W:0]      in_thr,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic [ACC_W-1:0]    out_pos,
  output logic [ACC_W-1:0]    out_neg
);

  localparam int unsigned    G        = (N_IN + LANES - 1) / LANES;
  localparam int unsigned    GW       = clog2(G + 1);
  localparam logic [GW-1:0]  LAST_GRP = GW'(G - 1);

  state_e               state_q;
  logic [N_IN*W-1:0]    act_q;
  logic [N_IN-1:0]      wpos_q;
  logic [N_IN-1:0]      wneg_q;
  logic [GW-1:0]        grp_q;
  logic [ACC_W-1:0]     pos_q, neg_q;
  logic [ACC_W-1:0]     pos_d, neg_d;
  logic [ACC_W-1:0]     part_pos_c, part_neg_c;
  logic                 in_ready_q, out_valid_q, out_bit_q;
  logic [ACC_W-1:0]     out_pos_q, out_neg_q;
  logic signed [ACC_W+1:0] diff_c;
  logic                 dec_c;
`ifdef TNN_THRESHOLD_EN
  logic [ACC_W:0]       thr_q;
  logic signed [ACC_W+1:0] thr_ext_c;
`endif

  tnn_lane_adder #(
    .N_IN  (N_IN),
    .W     (W),
    .LANES (LANES),
    .ACC_W (ACC_W),
    .GW    (GW)
  ) u_lane_adder (
    .act_i  (act_q),
    .wpos_i (wpos_q),
    .wneg_i (wneg_q),
    .grp_i  (grp_q),
    .pos_c  (part_pos_c),
    .neg_c  (part_neg_c)
  );

  assign pos_d = pos_q + part_pos_c;
  assign neg_d = neg_q + part_neg_c;

  // Decision on the sums that include the group being added this cycle
  always_comb begin
    diff_c = $signed({2'b00, pos_d}) - $signed({2'b00, neg_d});
`ifdef TNN_THRESHOLD_EN
    thr_ext_c = $signed({thr_q[ACC_W], thr_q});
    dec_c     = diff_c > thr_ext_c;
`else
    dec_c     = !diff_c[ACC_W+1] && (diff_c != '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_q       <= '0;
      wpos_q      <= '0;
      wneg_q      <= '0;
      grp_q       <= '0;
      pos_q       <= '0;
      neg_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_pos_q   <= '0;
      out_neg_q   <= '0;
`ifdef TNN_THRESHOLD_EN
      thr_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            act_q      <= in_act;
            wpos_q     <= in_wpos;
            wneg_q     <= in_wneg;
`ifdef TNN_THRESHOLD_EN
            thr_q      <= in_thr;
`endif
            grp_q      <= '0;
            pos_q      <= '0;
            neg_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          pos_q <= pos_d;
          neg_q <= neg_d;
          if (grp_q == LAST_GRP) begin
            out_valid_q <= 1'b1;
            out_bit_q   <= dec_c;
            out_pos_q   <= pos_d;
            out_neg_q   <= neg_d;
            state_q     <= DONE;
          end else begin
            grp_q <= grp_q + GW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_pos   = out_pos_q;
  assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_tnn_seq_neuron.sv
// Bench for tnn_seq_neuron: LANES=1 and LANES=2 instances against a behavioural model.
module tb_tnn_seq_neuron;

  localparam int unsigned N_IN  = 5;
  localparam int unsigned W     = 3;
  localparam int unsigned ACC_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_IN*W-1:0] in_act;
  logic [N_IN-1:0]   in_wpos, in_wneg;
  logic [ACC_W:0]    in_thr;
  logic              out_ready;
  logic              iv1, iv2, ir1, ir2, ov1, ov2, ob1, ob2;
  logic [ACC_W-1:0]  op1, op2, on1, on2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tnn_seq_neuron #(.N_IN(N_IN), .W(W), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_act(in_act), .in_wpos(in_wpos), .in_wneg(in_wneg),
`ifdef TNN_THRESHOLD_EN
    .in_thr(in_thr),
`endif
    .out_valid(ov1), .out_ready(out_ready), .out_bit(ob1), .out_pos(op1), .out_neg(on1)
  );

  tnn_seq_neuron #(.N_IN(N_IN), .W(W), .LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .in_act(in_act), .in_wpos(in_wpos), .in_wneg(in_wneg),
`ifdef TNN_THRESHOLD_EN
    .in_thr(in_thr),
`endif
    .out_valid(ov2), .out_ready(out_ready), .out_bit(ob2), .out_pos(op2), .out_neg(on2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic g_ov(input int sel);  return sel == 2 ? ov2 : ov1; endfunction
  function automatic logic g_ir(input int sel);  return sel == 2 ? ir2 : ir1; endfunction
  function automatic logic g_ob(input int sel);  return sel == 2 ? ob2 : ob1; endfunction
  function automatic logic [31:0] g_op(input int sel); return 32'(sel == 2 ? op2 : op1); endfunction
  function automatic logic [31:0] g_on(input int sel); return 32'(sel == 2 ? on2 : on1); endfunction

  task automatic set_iv(input int sel, input logic v);
    if (sel == 2) iv2 = v; else iv1 = v;
  endtask

  // One full transaction: accept, latency, result, optional backpressure, handshake
  task automatic run_vec(input int sel, input logic [N_IN*W-1:0] act,
                         input logic [N_IN-1:0] wp, input logic [N_IN-1:0] wn,
                         input int thr, input int bp, input bit hold_next);
    int p, n, a, thr_eff, g, cyc;
    logic exp_bit;
    p = 0; n = 0;
    for (int i = 0; i < int'(N_IN); i++) begin
      a = int'((act >> (W * i)) & 15'h7);
      if (wp[i] && !wn[i]) p += a;
      else if (wn[i] && !wp[i]) n += a;
    end
`ifdef TNN_THRESHOLD_EN
    thr_eff = thr;
`else
    thr_eff = 0;
`endif
    exp_bit = (p - n) > thr_eff;
    g = (sel == 2) ? 3 : 5;

    @(negedge clk);
    in_act = act; in_wpos = wp; in_wneg = wn; in_thr = (ACC_W+1)'(thr);
    set_iv(sel, 1'b1);
    check("in_ready_idle", 32'(g_ir(sel)), 1);
    @(negedge clk);
    set_iv(sel, 1'b0);
    in_act = 15'($urandom); in_wpos = 5'($urandom); in_wneg = 5'($urandom);
    in_thr = 7'($urandom);
    check("in_ready_busy", 32'(g_ir(sel)), 0);
    cyc = 0;
    while (!g_ov(sel) && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(g));
    check("out_bit", 32'(g_ob(sel)), 32'(exp_bit));
    check("out_pos", g_op(sel), 32'(p));
    check("out_neg", g_on(sel), 32'(n));
    for (int k = 0; k < bp; k++) begin
      if (hold_next) begin
        set_iv(sel, 1'b1);
        in_act = 15'($urandom);
      end
      @(negedge clk);
      check("bp_valid", 32'(g_ov(sel)), 1);
      check("bp_in_ready", 32'(g_ir(sel)), 0);
      check("bp_pos", g_op(sel), 32'(p));
      check("bp_neg", g_on(sel), 32'(n));
      check("bp_bit", 32'(g_ob(sel)), 32'(exp_bit));
    end
    set_iv(sel, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_valid_low", 32'(g_ov(sel)), 0);
    check("hs_in_ready", 32'(g_ir(sel)), 1);
  endtask

  initial begin
    rst_n = 1'b0; iv1 = 1'b0; iv2 = 1'b0; out_ready = 1'b0;
    in_act = '0; in_wpos = '0; in_wneg = '0; in_thr = '0;
    repeat (2) @(negedge clk);
    for (int s = 1; s <= 2; s++) begin
      check("rst_in_ready", 32'(g_ir(s)), 1);
      check("rst_out_valid", 32'(g_ov(s)), 0);
      check("rst_out_bit", 32'(g_ob(s)), 0);
      check("rst_out_pos", g_op(s), 0);
      check("rst_out_neg", g_on(s), 0);
    end
    rst_n = 1'b1;

    // {e,d,c,b,a} = {0,0,0,7,7}: pos 14
    run_vec(1, {3'd0, 3'd0, 3'd0, 3'd7, 3'd7}, 5'b00011, 5'b11100, 0, 0, 1'b0);
    // tie 6 vs 6, threshold -1
    run_vec(1, {3'd2, 3'd2, 3'd2, 3'd3, 3'd3}, 5'b00011, 5'b11100, -1, 0, 1'b0);
    // two lanes, partial last group
    run_vec(2, {3'd7, 3'd7, 3'd7, 3'd0, 3'd0}, 5'b00011, 5'b11100, 0, 0, 1'b0);
    // backpressure with a competing vector presented during DONE
    run_vec(1, {3'd1, 3'd0, 3'd0, 3'd5, 3'd6}, 5'b00011, 5'b11100, 0, 6, 1'b1);
    run_vec(2, {3'd3, 3'd1, 3'd2, 3'd4, 3'd4}, 5'b00011, 5'b11100, 0, 6, 1'b1);
    // all weights cancel
    run_vec(1, 15'($urandom), 5'b11111, 5'b11111, 0, 0, 1'b0);
    run_vec(2, 15'($urandom), 5'b11111, 5'b11111, 0, 0, 1'b0);

    // reset mid-accumulation
    @(negedge clk);
    in_act = {3'd0, 3'd0, 3'd0, 3'd7, 3'd7}; in_wpos = 5'b00011; in_wneg = 5'b11100;
    iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(ov1), 0);
    check("abort_in_ready", 32'(ir1), 1);
    check("abort_out_pos", 32'(op1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(1, {3'd0, 3'd0, 3'd0, 3'd7, 3'd7}, 5'b00011, 5'b11100, 0, 0, 1'b0);

    // randomized traffic on both widths
    for (int i = 0; i < 24; i++) begin
      run_vec((i % 2) + 1, 15'($urandom), 5'($urandom), 5'($urandom),
              int'($urandom_range(0, 24)) - 12, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
